// File: rtl/matmul_pkg.sv
// Shared types, defaults and width helpers for the matmul sequencer slice.
package matmul_pkg;

  localparam int N_DEF     = 2;
  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 17;

  typedef enum logic [2:0] {
    LOAD,
    CLR,
    MAC,
    WAIT,
    SEND,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter width for an index range of v values; never narrower than one bit.
  function automatic int idx_w(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

  // Result bytes per C element.
  function automatic int ob_of(input int acc_w);
    return (acc_w + 7) / 8;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Byte-stream handshake bundle: operand bytes in, result bytes out.
interface matmul_if
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/matmul_operand_rf.sv
// Operand storage: A occupies slots 0..N*N-1, B slots N*N..2*N*N-1, both row-major.
module matmul_operand_rf
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = idx_w(2 * N * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam int SLOTS = 2 * N * N;

  logic [DW-1:0] mem [SLOTS];

  // Single write port driven by the load counter; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) mem[s] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/matmul_seq.sv
// Matmul sequencer: loads A and B byte-serially, drives an external MAC per C
// element and streams each result LSB-first over a valid/ready byte port.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  matmul_if.slave          bus,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             busy,
  output logic             done
);

  localparam int OB    = ob_of(ACC_W);
  localparam int RW    = OB * 8;
  localparam int SLOTS = 2 * N * N;
  localparam int AW    = idx_w(SLOTS);
  localparam int IW    = idx_w(N);
  localparam int BW    = idx_w(OB);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [IW-1:0] i, j, k;
  logic [BW-1:0] b;
  logic [RW-1:0] res;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] rd_a, rd_b;
  logic          in_hs, out_hs;
  logic          last_in, last_k, last_b, last_elem;

  assign in_hs     = bus.in_valid && (state == LOAD);
  assign out_hs    = bus.out_ready && (state == SEND);
  assign last_in   = (cnt == AW'(SLOTS - 1));
  assign last_k    = (k == IW'(N - 1));
  assign last_b    = (b == BW'(OB - 1));
  assign last_elem = (i == IW'(N - 1)) && (j == IW'(N - 1));

  assign addr_a = AW'(int'(i) * N + int'(k));
  assign addr_b = AW'(N * N + int'(k) * N + int'(j));

  matmul_operand_rf #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (in_hs),
    .waddr   (cnt),
    .wdata   (bus.in_data),
    .raddr_a (addr_a),
    .raddr_b (addr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_hs && last_in) state_nxt = CLR;
      CLR:     state_nxt = MAC;
      MAC:     if (last_k) state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    if (out_hs && last_b) state_nxt = last_elem ? DONE : CLR;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Moore outputs; MAC operands are forced to zero outside MAC.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    mac_clr       = 1'b0;
    mac_en        = 1'b0;
    mac_a         = '0;
    mac_b         = '0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
      end
      CLR:  mac_clr = 1'b1;
      MAC: begin
        mac_en = 1'b1;
        mac_a  = rd_a;
        mac_b  = rd_b;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = res[7:0];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Counters and result register; res shifts right so the current byte is always res[7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      b   <= '0;
      res <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          i <= '0;
          j <= '0;
          if (in_hs) cnt <= last_in ? '0 : cnt + 1'b1;
        end
        CLR:  k <= '0;
        MAC:  k <= k + 1'b1;
        WAIT: begin
          res <= RW'(mac_acc);
          b   <= '0;
        end
        SEND: begin
          if (out_hs) begin
            res <= res >> 8;
            b   <= b + 1'b1;
            if (last_b) begin
              if (j == IW'(N - 1)) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end
          end
        end
        DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a behavioural MAC model.
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 17;

  logic             clk = 1'b0;
  logic             rst;
  logic             mac_clr, mac_en;
  logic [DW-1:0]    mac_a, mac_b;
  logic [ACC_W-1:0] mac_acc;
  logic             busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic junk   = 1'b0;

  logic [7:0] op_c1  [8]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  logic [7:0] op_c2  [8]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] exp_c1 [12] = '{8'h13, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00,
                              8'h2B, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00};
  logic [7:0] exp_c2 [12] = '{8'h02, 8'hFC, 8'h01, 8'h02, 8'hFC, 8'h01,
                              8'h02, 8'hFC, 8'h01, 8'h02, 8'hFC, 8'h01};

  always #5 clk = ~clk;

  matmul_if #(.DW(DW)) bus ();

  matmul_seq #(
    .N     (N),
    .DW    (DW),
    .ACC_W (ACC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_acc (mac_acc),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural MAC: registered accumulator.
  always @(posedge clk) begin
    if (rst)         mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // MAC-side invariants, sampled on the falling edge.
  always @(negedge clk) begin
    check("mac_clr_en_exclusive", 32'(mac_clr && mac_en), 32'd0);
    check("mac_ops_zero_when_idle", 32'(!mac_en && (mac_a != '0 || mac_b != '0)), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int sel, input int gaps);
    for (int n = 0; n < 2 * N * N; n++) begin
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (sel == 1) ? op_c1[n] : op_c2[n];
      check($sformatf("in_ready_load%0d", n), 32'(bus.in_ready), 32'd1);
      tick();
      last_acc = cyc;
    end
    bus.in_valid = junk;
    bus.in_data  = 8'hA5;
  endtask

  // mode 0: out_ready always 1; mode 1: random backpressure with a forced 10-cycle stall.
  task automatic collect(input int sel, input int mode, input int nbytes);
    int         got, guard, hs_edge, stall;
    logic       held, fresh, rdy, did_long;
    logic [7:0] held_d, e;
    got = 0; guard = 0; hs_edge = last_acc; stall = 0;
    held = 1'b0; fresh = 1'b1; did_long = 1'b0; held_d = '0;
    while (got < nbytes && guard < 3000) begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end
      if (bus.out_valid) begin
        if (fresh) begin
          check($sformatf("latency_elem%0d", got / 3), 32'(cyc - hs_edge), 32'(N + 2));
          fresh = 1'b0;
        end
        if (held) check("stall_data_stable", 32'(bus.out_data), 32'(held_d));
        if (mode == 0) rdy = 1'b1;
        else if (stall > 0) begin rdy = 1'b0; stall--; end
        else if (got == 1 && !did_long) begin rdy = 1'b0; stall = 9; did_long = 1'b1; end
        else rdy = 1'($urandom_range(0, 1));
        bus.out_ready = rdy;
        if (rdy) begin
          e = (sel == 1) ? exp_c1[got] : exp_c2[got];
          check($sformatf("byte%0d", got), 32'(bus.out_data), 32'(e));
          got++;
          held = 1'b0;
          if (got % 3 == 0) begin
            fresh   = 1'b1;
            hs_edge = cyc + 1;
          end
        end else begin
          held   = 1'b1;
          held_d = bus.out_data;
        end
      end else begin
        if (held) check("stall_valid_held", 32'(bus.out_valid), 32'd1);
        held = 1'b0;
        bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      guard++;
    end
    if (guard >= 3000) check("collect_timeout", 32'(got), 32'(nbytes));
  endtask

  task automatic finish_run();
    bus.in_valid = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("done_cleared", 32'(done), 32'd0);
    check("busy_dropped", 32'(busy), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mac_clr", 32'(mac_clr), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    rst = 1'b0;

    // Case 1: basic product.
    load(1, 0);
    collect(1, 0, 12);
    finish_run();

    // Case 6: back-to-back reload the cycle after done.
    load(1, 0);
    collect(1, 0, 12);
    finish_run();

    // Case 2: all 0xFF operands, with gaps between input bytes.
    load(2, 2);
    collect(2, 0, 12);
    finish_run();

    // Case 3: random backpressure.
    load(1, 0);
    collect(1, 1, 12);
    finish_run();

    // Case 4: junk on the input while busy.
    junk = 1'b1;
    load(1, 0);
    collect(1, 0, 12);
    junk = 1'b0;
    finish_run();

    // Case 5: reset during SEND of C[0][1], then clean reload.
    load(1, 0);
    collect(1, 0, 4);
    check("mid_send_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mac_clr", 32'(mac_clr), 32'd0);
    check("midrst_mac_en", 32'(mac_en), 32'd0);
    rst = 1'b0;
    load(2, 0);
    collect(2, 0, 12);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
